// File: rtl/hex_display_pkg.sv
// Shared constants for the Avalon seven-segment display slave:
// register offsets, CTRL layout, segment table, blank pattern.
package hex_display_pkg;

  localparam logic [3:0] ADDR_DIGIT0    = 4'd0;
  localparam logic [3:0] ADDR_CTRL      = 4'd8;
  localparam logic [3:0] ADDR_BLINK_DIV = 4'd9;
  localparam logic [3:0] ADDR_STATUS    = 4'd10;

  localparam int CTRL_HEX_LSB   = 0;
  localparam int CTRL_BLINK_LSB = 8;
  localparam int CTRL_BLANK_BIT = 16;

  typedef struct packed {
    logic       blank;
    logic [7:0] blink_en;
    logic [7:0] hex_en;
  } ctrl_t;

  // Active-high g..a patterns, entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] blank_pattern(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/avalon_hex_display_hex7seg.sv
// Combinational nibble to seven-segment (g..a, active-high) decoder.
module hex7seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/avalon_hex_display.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits with
// per-digit hex/raw select, blinking prescaler and global blank.
module avalon_hex_display
  import hex_display_pkg::*;
#(
  parameter int          NUM_DIGITS      = 6,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter logic [31:0] CTRL_RESET      = 32'h0000_00FF,
  parameter logic [31:0] BLINK_DIV_RESET = 32'd25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] hex_out
);

  localparam logic [7:0] DMASK = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [3:0] NDIG  = 4'(NUM_DIGITS);
  localparam logic [7:0] BLANK = blank_pattern(ACTIVE_LOW);

  function automatic ctrl_t to_ctrl(input logic [16:0] w);
    ctrl_t c;
    c.hex_en   = w[CTRL_HEX_LSB +: 8] & DMASK;
    c.blink_en = w[CTRL_BLINK_LSB +: 8] & DMASK;
    c.blank    = w[CTRL_BLANK_BIT];
    return c;
  endfunction

  logic [7:0]  digit_q [8];
  logic [7:0]  digit_d [8];
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
  logic        wr_en;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (div_q == 32'd0) begin
      cnt_d   = 32'd0;
      phase_d = 1'b1;
    end else if (cnt_q == 32'd0) begin
      cnt_d   = div_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
    // A divider write overrides any reload in the same cycle.
    if (wr_en) begin
      unique case (1'b1)
        (address < ADDR_CTRL): begin
          if (address < NDIG)
            digit_d[address[2:0]] = writedata[7:0];
        end
        (address == ADDR_CTRL): ctrl_d = to_ctrl(writedata[16:0]);
        (address == ADDR_BLINK_DIV): begin
          div_d   = writedata;
          cnt_d   = writedata;
          phase_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (chipselect) begin
      unique case (1'b1)
        (address < NDIG):
          readdata = {24'd0, digit_q[address[2:0]]};
        (address == ADDR_CTRL):
          readdata = {15'd0, ctrl_q};
        (address == ADDR_BLINK_DIV):
          readdata = div_q;
        (address == ADDR_STATUS):
          readdata = {31'd0, phase_q};
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [6:0] seg;
    logic [7:0] pat;
    logic       off;

    hex7seg_decoder u_dec (
      .nibble_i (digit_q[g][3:0]),
      .seg_o    (seg)
    );

    assign pat = ctrl_q.hex_en[g] ? {digit_q[g][7], seg} : digit_q[g];
    assign off = ctrl_q.blank | (ctrl_q.blink_en[g] & ~phase_q);
    assign hex_d[8*g +: 8] = off ? BLANK
                           : (ACTIVE_LOW ? ~pat : pat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '{default: 8'd0};
      ctrl_q  <= to_ctrl(CTRL_RESET[16:0]);
      div_q   <= BLINK_DIV_RESET;
      cnt_q   <= BLINK_DIV_RESET;
      phase_q <= 1'b1;
      hex_q   <= {NUM_DIGITS{BLANK}};
    end else begin
      digit_q <= digit_d;
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign hex_out = hex_q;

endmodule

// File: tb/tb_avalon_hex_display.sv
// Directed scoreboard bench for avalon_hex_display (8-digit and
// 4-digit instances, active-low pins).
module tb_avalon_hex_display;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cs, wn;
  logic [3:0]  addr;
  logic [31:0] wd, rd;
  logic [63:0] hex;

  logic        rst4, cs4, wn4;
  logic [3:0]  addr4;
  logic [31:0] wd4, rd4;
  logic [31:0] hex4;

  int n_checks = 0;
  int n_fail   = 0;

  string       tag_q[$];
  logic [63:0] exp_q[$];

  avalon_hex_display #(.NUM_DIGITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (addr),
    .chipselect (cs),
    .write_n    (wn),
    .writedata  (wd),
    .readdata   (rd),
    .hex_out    (hex)
  );

  avalon_hex_display #(
    .NUM_DIGITS      (4),
    .BLINK_DIV_RESET (32'd2)
  ) dut4 (
    .clk        (clk),
    .reset      (rst4),
    .address    (addr4),
    .chipselect (cs4),
    .write_n    (wn4),
    .writedata  (wd4),
    .readdata   (rd4),
    .hex_out    (hex4)
  );

  task automatic expect_val(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    string       tag;
    logic [63:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    cs = 1'b0; wn = 1'b1;
    cs4 = 1'b0; wn4 = 1'b1;
  endtask

  task automatic wr(input bit d4, input logic [3:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    if (d4) begin
      cs4 = 1'b1; wn4 = 1'b0; addr4 = a; wd4 = d;
    end else begin
      cs = 1'b1; wn = 1'b0; addr = a; wd = d;
    end
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic rd_chk(input bit d4, input logic [3:0] a,
                        input string tag, input logic [31:0] exp);
    expect_val(tag, {32'd0, exp});
    @(negedge clk);
    if (d4) begin
      cs4 = 1'b1; wn4 = 1'b1; addr4 = a;
    end else begin
      cs = 1'b1; wn = 1'b1; addr = a;
    end
    #1;
    check({32'd0, d4 ? rd4 : rd});
    bus_idle();
  endtask

  initial begin
    bit seen;
    reset = 1'b1; rst4 = 1'b1;
    addr = '0; wd = '0; addr4 = '0; wd4 = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; rst4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_val("reset_hex", {8{8'hC0}});
    check(hex);
    expect_val("reset_hex4", {32'd0, {4{8'hC0}}});
    check({32'd0, hex4});
    rd_chk(0, 4'd8, "reset_ctrl", 32'h0000_00FF);
    rd_chk(0, 4'd10, "reset_status", 32'd1);
    rd_chk(0, 4'd9, "reset_div", 32'd25000000);
    rd_chk(1, 4'd8, "ctrl4_masked", 32'h0000_000F);

    // Hex digit with dp, checking 2-cycle latency.
    wr(0, 4'd2, 32'h8A);
    expect_val("dig2_not_yet", {8{8'hC0}});
    check(hex);
    @(posedge clk); #1;
    expect_val("dig2_hex_dp", 64'hC0C0C0C0_C008C0C0);
    check(hex);
    wr(0, 4'd2, 32'h1234_56AB);
    rd_chk(0, 4'd2, "dig2_read", 32'h0000_00AB);

    // Raw mode on all digits.
    wr(0, 4'd8, 32'h0);
    wr(0, 4'd0, 32'h55);
    @(posedge clk); #1;
    expect_val("raw_mode", 64'hFFFFFFFF_FF54FFAA);
    check(hex);

    // Blink digit 0 with period 4.
    wr(0, 4'd9, 32'd3);
    wr(0, 4'd8, 32'h0000_01FF);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      expect_val("blink_d0",
        {48'd0, 8'hC0, ((((i + 1) / 4) % 2) == 0) ? 8'h92 : 8'hFF});
      check({48'd0, hex[15:0]});
    end
    wr(0, 4'd9, 32'd0);
    rd_chk(0, 4'd10, "status_div0", 32'd1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_val("steady_div0", 64'h92);
      check({56'd0, hex[7:0]});
    end

    // Global blank and release.
    wr(0, 4'd8, 32'h0001_00FF);
    @(posedge clk); #1;
    expect_val("blank_all", {8{8'hFF}});
    check(hex);
    wr(0, 4'd8, 32'h0000_00FF);
    @(posedge clk); #1;
    expect_val("unblank", 64'hC0C0C0C0_C003C092);
    check(hex);

    // Four-digit instance: out-of-range and unmapped writes.
    wr(1, 4'd6, 32'h12);
    rd_chk(1, 4'd6, "d4_addr6", 32'd0);
    wr(1, 4'd12, 32'h55);
    rd_chk(1, 4'd12, "d4_addr12", 32'd0);
    @(posedge clk); #1;
    expect_val("d4_hex_unchanged", {32'd0, {4{8'hC0}}});
    check({32'd0, hex4});
    wr(1, 4'd8, 32'h0000_FFFF);
    rd_chk(1, 4'd8, "d4_ctrl_mask", 32'h0000_0F0F);

    // Reset while blinking in the dark phase.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (hex4 == 32'hFFFF_FFFF) seen = 1'b1;
    end
    expect_val("d4_dark_seen", 64'd1);
    check({63'd0, seen});
    expect_val("d4_phase_low", 64'd0);
    @(negedge clk);
    cs4 = 1'b1; wn4 = 1'b1; addr4 = 4'd10;
    #1;
    check({32'd0, rd4});
    bus_idle();
    rst4 = 1'b1;
    @(posedge clk); #1;
    expect_val("d4_rst_blank", {32'd0, 32'hFFFF_FFFF});
    check({32'd0, hex4});
    rd_chk(1, 4'd10, "d4_rst_phase", 32'd1);
    rd_chk(1, 4'd8, "d4_rst_ctrl", 32'h0000_000F);
    @(negedge clk);
    rst4 = 1'b0;
    @(posedge clk); #1;
    expect_val("d4_after_rst", {32'd0, {4{8'hC0}}});
    check({32'd0, hex4});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
